// File: rtl/maze_pkg.sv
// Shared types and neighbour helper for the rat-in-maze solver.
// Neighbour coordinates are carried 16 bits wide so any grid size fits.
package maze_pkg;

  typedef enum logic [1:0] {
    UP,
    RIGHT,
    DOWN,
    LEFT
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    PROBE,
    WAIT,
    BACK,
    DONE,
    FAIL,
    REPLAY
  } state_t;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic        oob;
  } nbr_t;

  function automatic nbr_t neighbour(
    input logic [15:0] row,
    input logic [15:0] col,
    input dir_t        dir,
    input logic [15:0] row_max,
    input logic [15:0] col_max
  );
    nbr_t n;
    n.row = row;
    n.col = col;
    n.oob = 1'b0;
    unique case (dir)
      UP: begin
        n.oob = (row == 16'd0);
        n.row = row - 16'd1;
      end
      RIGHT: begin
        n.oob = (col == col_max);
        n.col = col + 16'd1;
      end
      DOWN: begin
        n.oob = (row == row_max);
        n.row = row + 16'd1;
      end
      LEFT: begin
        n.oob = (col == 16'd0);
        n.col = col - 16'd1;
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/maze_solver_p_path_stack.sv
// DFS path stack: push, pop, top-entry dir update and indexed read.
// Entries are {row, col, dir}; dir occupies the two LSBs.
module path_stack #(
  parameter int DEPTH = 16,
  parameter int EW    = 10,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            upd_i,
  input  logic [1:0]      dir_i,
  input  logic [EW-1:0]   data_i,
  input  logic [SP_W-1:0] idx_i,
  output logic [EW-1:0]   data_o,
  output logic [SP_W-1:0] sp_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] ONE = SP_W'(1);

  logic [EW-1:0]   mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [IW-1:0]   wr_a;
  logic [IW-1:0]   top_a;
  logic [IW-1:0]   rd_a;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign sp_o    = sp_q;
  assign wr_a    = sp_q[IW-1:0];
  assign top_a   = IW'(sp_q - ONE);
  assign rd_a    = idx_i[IW-1:0];
  assign data_o  = mem_q[rd_a];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else if (clr_i) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      sp_q <= sp_q + ONE;
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clr_i) begin
      mem_q[wr_a] <= data_i;
    end else if (upd_i && !empty_o) begin
      mem_q[top_a][1:0] <= dir_i;
    end
  end

endmodule

// File: rtl/maze_solver_p.sv
// Depth-first maze solver with backtracking and path replay.
// Memory strobes decode from state and the registered cur/dir.
module maze_solver_p
  import maze_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int COL_W = 4,
  parameter int DEPTH = 2 ** (ROW_W + COL_W),
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   run,
  input  logic [ROW_W-1:0]       src_row,
  input  logic [COL_W-1:0]       src_col,
  input  logic [ROW_W-1:0]       dst_row,
  input  logic [COL_W-1:0]       dst_col,
  output logic [ROW_W+COL_W-1:0] mem_addr,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic                   mem_wdata,
  input  logic                   mem_rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic                   ovf,
  output logic                   move,
  output logic [ROW_W-1:0]       path_row,
  output logic [COL_W-1:0]       path_col,
  output logic [SP_W-1:0]        path_len
);

  localparam int EW = ROW_W + COL_W + 2;
  localparam logic [SP_W-1:0] ONE = SP_W'(1);
  localparam logic [SP_W-1:0] TWO = SP_W'(2);

  state_t          state_q;
  dir_t            dir_q;
  logic [ROW_W-1:0] cur_row_q, dst_row_q;
  logic [COL_W-1:0] cur_col_q, dst_col_q;
  logic [SP_W-1:0] idx_q, len_q;
  logic            done_q, fail_q, ovf_q;

  nbr_t            nb;
  logic [ROW_W-1:0] nb_row, top_row;
  logic [COL_W-1:0] nb_col, top_col;
  dir_t            top_dir;
  logic            go, at_dst;
  logic            st_push, st_pop, st_upd;
  logic            st_full, st_empty;
  logic [SP_W-1:0] st_sp, st_idx;
  logic [EW-1:0]   st_rd;

  assign nb = neighbour(16'(cur_row_q), 16'(cur_col_q), dir_q,
                        16'((2 ** ROW_W) - 1), 16'((2 ** COL_W) - 1));
  assign nb_row  = nb.row[ROW_W-1:0];
  assign nb_col  = nb.col[COL_W-1:0];
  assign top_row = st_rd[EW-1 -: ROW_W];
  assign top_col = st_rd[2 +: COL_W];
  assign top_dir = dir_t'(st_rd[1:0]);
  assign at_dst  = (cur_row_q == dst_row_q) && (cur_col_q == dst_col_q);
  assign go      = start && (state_q inside {IDLE, DONE, FAIL});

  always_comb begin
    st_push  = (state_q == MARK);
    st_pop   = (state_q == BACK);
    st_upd   = (state_q == WAIT) && !mem_rdata;
    st_idx   = (state_q == REPLAY) ? idx_q : st_sp - TWO;
    mem_wr   = (state_q == MARK);
    mem_rd   = (state_q == PROBE) && !nb.oob;
    mem_addr = '0;
    if (mem_wr) mem_addr = {cur_row_q, cur_col_q};
    else if (mem_rd) mem_addr = {nb_row, nb_col};
  end

  path_stack #(
    .DEPTH(DEPTH),
    .EW   (EW),
    .SP_W (SP_W)
  ) u_stack (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (go),
    .push_i (st_push),
    .pop_i  (st_pop),
    .upd_i  (st_upd),
    .dir_i  (2'(dir_q)),
    .data_i ({cur_row_q, cur_col_q, 2'(UP)}),
    .idx_i  (st_idx),
    .data_o (st_rd),
    .sp_o   (st_sp),
    .full_o (st_full),
    .empty_o(st_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dir_q     <= UP;
      cur_row_q <= '0;
      cur_col_q <= '0;
      dst_row_q <= '0;
      dst_col_q <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (go) begin
      state_q   <= MARK;
      cur_row_q <= src_row;
      cur_col_q <= src_col;
      dst_row_q <= dst_row;
      dst_col_q <= dst_col;
      len_q     <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state_q)
        MARK: begin
          if (st_full) begin
            state_q <= FAIL;
            fail_q  <= 1'b1;
            ovf_q   <= 1'b1;
          end else if (at_dst) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            len_q   <= st_sp + ONE;
          end else begin
            dir_q   <= UP;
            state_q <= PROBE;
          end
        end
        PROBE: begin
          if (!nb.oob) state_q <= WAIT;
          else if (dir_q == LEFT) state_q <= BACK;
          else dir_q <= dir_t'(dir_q + 2'd1);
        end
        WAIT: begin
          if (!mem_rdata) begin
            cur_row_q <= nb_row;
            cur_col_q <= nb_col;
            state_q   <= MARK;
          end else if (dir_q == LEFT) begin
            state_q <= BACK;
          end else begin
            dir_q   <= dir_t'(dir_q + 2'd1);
            state_q <= PROBE;
          end
        end
        BACK: begin
          // popping the last entry means every branch from src is dead
          if (st_sp == ONE) begin
            state_q <= FAIL;
            fail_q  <= 1'b1;
          end else begin
            cur_row_q <= top_row;
            cur_col_q <= top_col;
            if (top_dir == LEFT) begin
              dir_q <= LEFT;
            end else begin
              dir_q   <= dir_t'(top_dir + 2'd1);
              state_q <= PROBE;
            end
          end
        end
        DONE: begin
          if (run) begin
            idx_q   <= '0;
            state_q <= REPLAY;
          end
        end
        REPLAY: begin
          idx_q <= idx_q + ONE;
          if (idx_q == st_sp - ONE) state_q <= DONE;
        end
        default: ;
      endcase
    end
  end

  assign busy      = state_q inside {MARK, PROBE, WAIT, BACK, REPLAY};
  assign move      = (state_q == REPLAY);
  assign path_row  = move ? top_row : '0;
  assign path_col  = move ? top_col : '0;
  assign done      = done_q;
  assign fail      = fail_q;
  assign ovf       = ovf_q;
  assign path_len  = len_q;
  assign mem_wdata = 1'b1;

endmodule

// File: tb/tb_maze_solver_p.sv
// Bench for maze_solver_p on a 4x4 grid, plus a 3-deep stack instance.
// Replay cells are queued when run is driven and checked as moves appear.
module tb_maze_solver_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, run0 = 1'b0;
  logic [1:0] sr0 = '0, sc0 = '0, dr0 = '0, dc0 = '0;
  logic [3:0] addr0;
  logic       rd0, wr0, wd0, busy0, done0, fail0, ovf0, move0;
  logic       rdata0 = 1'b0;
  logic [1:0] pr0, pc0;
  logic [4:0] plen0;

  logic       start1 = 1'b0, run1 = 1'b0;
  logic [1:0] sr1 = '0, sc1 = '0, dr1 = '0, dc1 = '0;
  logic [3:0] addr1;
  logic       rd1, wr1, wd1, busy1, done1, fail1, ovf1, move1;
  logic       rdata1 = 1'b0;
  logic [1:0] pr1, pc1;
  logic [1:0] plen1;

  logic [15:0] mem0 = '0, mem1 = '0, ldv0 = '0, ldv1 = '0;
  logic        ld0 = 1'b0, ld1 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int edges, wcnt;
  logic [3:0] waddr;
  logic mv_seen;
  logic [3:0] expq[$];

  maze_solver_p #(.ROW_W(2), .COL_W(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .run(run0),
    .src_row(sr0), .src_col(sc0), .dst_row(dr0), .dst_col(dc0),
    .mem_addr(addr0), .mem_rd(rd0), .mem_wr(wr0),
    .mem_wdata(wd0), .mem_rdata(rdata0),
    .busy(busy0), .done(done0), .fail(fail0), .ovf(ovf0),
    .move(move0), .path_row(pr0), .path_col(pc0),
    .path_len(plen0)
  );

  maze_solver_p #(.ROW_W(2), .COL_W(2), .DEPTH(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .run(run1),
    .src_row(sr1), .src_col(sc1), .dst_row(dr1), .dst_col(dc1),
    .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1),
    .mem_wdata(wd1), .mem_rdata(rdata1),
    .busy(busy1), .done(done1), .fail(fail1), .ovf(ovf1),
    .move(move1), .path_row(pr1), .path_col(pc1),
    .path_len(plen1)
  );

  always @(posedge clk) begin
    if (ld0) mem0 <= ldv0;
    else if (wr0) mem0[addr0] <= 1'b1;
    if (rd0) rdata0 <= mem0[addr0];
    if (ld1) mem1 <= ldv1;
    else if (wr1) mem1[addr1] <= 1'b1;
    if (rd1) rdata1 <= mem1[addr1];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load0(input logic [15:0] v);
    @(negedge clk);
    ldv0 = v;
    ld0 = 1'b1;
    @(negedge clk);
    ld0 = 1'b0;
  endtask

  task automatic load1(input logic [15:0] v);
    @(negedge clk);
    ldv1 = v;
    ld1 = 1'b1;
    @(negedge clk);
    ld1 = 1'b0;
  endtask

  task automatic solve0(input logic [1:0] sr, sc, dr, dc, input bit with_run);
    @(negedge clk);
    sr0 = sr; sc0 = sc; dr0 = dr; dc0 = dc;
    start0 = 1'b1;
    run0 = with_run;
    @(negedge clk);
    start0 = 1'b0;
    run0 = 1'b0;
    edges = 1;
    wcnt = 0;
    mv_seen = 1'b0;
    forever begin
      if (wr0) begin
        wcnt++;
        waddr = addr0;
      end
      mv_seen |= move0;
      if (done0 || fail0 || edges >= 500) break;
      @(negedge clk);
      edges++;
    end
    if (!(done0 || fail0)) check("solve_timeout", 0, 1);
  endtask

  task automatic replay0(input int n, input bit poke);
    int k;
    k = 0;
    @(negedge clk);
    run0 = 1'b1;
    @(negedge clk);
    run0 = 1'b0;
    while (move0 && k < 64) begin
      if (expq.size() == 0) check("replay_extra", 32'(k), 32'(n));
      else check("replay_cell", 32'({pr0, pc0}), 32'(expq.pop_front()));
      k++;
      start0 = poke && (k == 1);
      @(negedge clk);
    end
    start0 = 1'b0;
    check("replay_len", 32'(k), 32'(n));
    check("replay_end", 32'({done0, busy0}), 32'b10);
    expq.delete();
  endtask

  initial begin
    int k;
    #2 rst = 1'b0;
    #1;
    check("rst_outs0", 32'({busy0, done0, fail0, ovf0, move0, rd0, wr0,
                            plen0, pr0, pc0, addr0}), 0);
    check("rst_outs1", 32'({busy1, done1, fail1, ovf1, move1, rd1, wr1,
                            plen1, pr1, pc1, addr1}), 0);
    check("wdata", 32'({wd0, wd1}), 32'b11);
    @(negedge clk);
    rst = 1'b1;

    // straight run along row 0
    load0(16'h0000);
    solve0(2'd0, 2'd0, 2'd0, 2'd3, 1'b0);
    check("straight_edges", 32'(edges), 14);
    check("straight_flags", 32'({done0, fail0, ovf0, busy0}), 32'b1000);
    check("straight_len", 32'(plen0), 4);
    check("straight_marks", 32'(mem0), 32'h000f);
    expq = '{4'h0, 4'h1, 4'h2, 4'h3};
    replay0(4, 1'b0);

    // start and run together from DONE: restart, no replay
    load0(16'h0000);
    solve0(2'd0, 2'd0, 2'd0, 2'd3, 1'b1);
    check("collide_nomove", 32'(mv_seen), 0);
    check("collide_done", 32'({done0, plen0}), 32'({1'b1, 5'd4}));
    expq = '{4'h0, 4'h1, 4'h2, 4'h3};
    replay0(4, 1'b1);
    check("poke_ignored", 32'({done0, busy0, fail0}), 32'b100);

    // walled-in source
    load0(16'h0252);
    solve0(2'd1, 2'd1, 2'd3, 2'd3, 1'b0);
    check("walled_flags", 32'({done0, fail0, ovf0}), 32'b010);
    check("walled_len", 32'(plen0), 0);
    check("walled_wcnt", 32'(wcnt), 1);
    check("walled_waddr", 32'(waddr), 5);

    // dead end at (0,1), real path down column 0
    load0(16'heeec);
    solve0(2'd0, 2'd0, 2'd3, 2'd0, 1'b0);
    check("back_flags", 32'({done0, fail0}), 32'b10);
    check("back_len", 32'(plen0), 4);
    check("back_deadend", 32'(mem0[1]), 1);
    expq = '{4'h0, 4'h4, 4'h8, 4'hc};
    replay0(4, 1'b0);

    // 3-deep stack cannot hold a 4-cell path
    load1(16'h0000);
    @(negedge clk);
    sr1 = 2'd0; sc1 = 2'd0; dr1 = 2'd0; dc1 = 2'd3;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (!(done1 || fail1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ovf_flags", 32'({done1, fail1, ovf1, busy1}), 32'b0110);
    check("ovf_len", 32'(plen1), 0);

    // reset in the middle of a search
    load0(16'h0000);
    @(negedge clk);
    sr0 = 2'd0; sc0 = 2'd0; dr0 = 2'd3; dc0 = 2'd3;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (!rd0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("saw_probe", 32'(rd0), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_outs", 32'({busy0, done0, fail0, ovf0, move0, rd0, wr0,
                              plen0, pr0, pc0, addr0}), 0);
    check("midrst_outs1", 32'({busy1, fail1, ovf1}), 0);
    @(negedge clk);
    rst = 1'b1;
    load0(16'h0000);
    solve0(2'd0, 2'd0, 2'd3, 2'd3, 1'b0);
    check("after_rst", 32'({done0, fail0, plen0}), 32'({2'b10, 5'd7}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
